// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and the
// oversampling baud divider calculation.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Clocks per oversampling tick, floored, never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int div;
    div = clk_freq / (baud * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clk tick every DIV clocks while run is high.
// restart realigns the divider to the current clock; shared with the transmitter.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && !restart && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// configurable frame format and error flags. Define UART_RX_BREAK_DET_EN for break_det.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 break_det
`endif
);

  localparam int            DIV       = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int            PW        = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_LAST   = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_S0     = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_S1     = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_MID    = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  logic                 sync1, sync2, hist;
  logic                 rx_s, fall;
  rx_state_t            state, state_next;
  logic                 run, restart, tick, mid;
  logic [PW-1:0]        phase;
  logic                 v0, v1, maj;
  logic [3:0]           cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_exp, par_err_q, frm_err_q, frm_err_next;
  logic                 shift_en, par_chk, stop_chk, finish;

  // Reset high so leaving reset on an idle line never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rx_s = sync2;
  assign fall = hist & ~sync2;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (!run || restart) begin
      phase <= '0;
    end else if (tick) begin
      phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
    end
  end

  assign mid          = tick && (phase == PH_MID);
  assign maj          = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign par_exp      = (PARITY == PARITY_ODD) ? ~^shreg : ^shreg;
  assign frm_err_next = frm_err_q | ~maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (fall) state_next = ST_START;
      ST_START:  if (mid) state_next = maj ? ST_IDLE : ST_DATA;
      ST_DATA:   if (mid && cnt == LAST_DATA)
                   state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (mid) state_next = ST_STOP;
      ST_STOP:   if (mid && cnt == LAST_STOP) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // NOTE: every output of this block is given a default before the case so
  // that no state leaves a signal unassigned and infers a latch.
  always_comb begin
    run      = 1'b1;
    restart  = 1'b0;
    rx_busy  = 1'b1;
    shift_en = 1'b0;
    par_chk  = 1'b0;
    stop_chk = 1'b0;
    finish   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        run     = 1'b0;
        rx_busy = 1'b0;
        restart = fall;
      end
      ST_DATA:   shift_en = mid;
      ST_PARITY: par_chk  = mid;
      ST_STOP: begin
        stop_chk = mid;
        finish   = mid && (cnt == LAST_STOP);
      end
      default: ;
    endcase
  end

  // Bit counter restarts on every state change, so it serves both DATA and STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      if (tick && phase == PH_S0) v0 <= rx_s;
      if (tick && phase == PH_S1) v1 <= rx_s;
      if (state_next != state) begin
        cnt <= '0;
      end else if (mid) begin
        cnt <= cnt + 4'd1;
      end
      if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (state == ST_START) begin
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
      end else begin
        if (par_chk && (maj != par_exp)) par_err_q <= 1'b1;
        if (stop_chk && !maj)            frm_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_valid <= finish;
      if (finish) begin
        rx_data    <= shreg;
        frame_err  <= frm_err_next;
        parity_err <= par_err_q;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // An all-zero word with a missing stop bit is a break; hold until the line idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      break_det <= 1'b0;
    end else if (finish && shreg == '0 && frm_err_next) begin
      break_det <= 1'b1;
    end else if (rx_s) begin
      break_det <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three configurations (8N1 default rate,
// 8E1 fast, 7O2 fast) driven with directed and random frames against a frame model.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD_B   = 1_000_000;
  localparam int OS_B     = 8;
  localparam int BAUD_C   = 500_000;
  localparam int OS_C     = 10;
  localparam int BIT_A    = (CLK_FREQ / (115_200 * 16)) * 16;
  localparam int BIT_B    = (CLK_FREQ / (BAUD_B * OS_B)) * OS_B;
  localparam int BIT_C    = (CLK_FREQ / (BAUD_C * OS_C)) * OS_C;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic       valid_a, valid_b, valid_c;
  logic       busy_a, busy_b, busy_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       perr_a, perr_b, perr_c;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk_a, brk_b, brk_c;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  rec_t q_a[$], q_b[$], q_c[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param u_dut_a (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_busy(busy_a), .frame_err(ferr_a), .parity_err(perr_a)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk_a)
`endif
  );

  uart_rx_param #(.BAUD(BAUD_B), .OVERSAMPLE(OS_B), .PARITY(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_busy(busy_b), .frame_err(ferr_b), .parity_err(perr_b)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk_b)
`endif
  );

  uart_rx_param #(.BAUD(BAUD_C), .OVERSAMPLE(OS_C), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_c), .rx_data(data_c), .rx_valid(valid_c),
    .rx_busy(busy_c), .frame_err(ferr_c), .parity_err(perr_c)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk_c)
`endif
  );

  // Capture every rx_valid pulse with the outputs and the cycle it appeared in.
  always @(negedge clk) begin
    if (valid_a === 1'b1) q_a.push_back('{data: {1'b0, data_a}, fe: ferr_a, pe: perr_a, cyc: cyc});
    if (valid_b === 1'b1) q_b.push_back('{data: {1'b0, data_b}, fe: ferr_b, pe: perr_b, cyc: cyc});
    if (valid_c === 1'b1) q_c.push_back('{data: {2'b00, data_c}, fe: ferr_c, pe: perr_c, cyc: cyc});
  end

  // Reference: what a receiver must report for a frame, from the frame's bit content.
  function automatic rec_t model(input logic [8:0] data, input int nbits, input int par_mode,
                                 input logic pbit, input logic [1:0] stops, input int nstop);
    rec_t r;
    int   ones;
    r.data = 9'(int'(data) % (1 << nbits));
    ones   = $countones(r.data) + ((par_mode != 0) ? int'(pbit) : 0);
    r.pe   = (par_mode == 1) ? (ones % 2 == 0) : (par_mode == 2) ? (ones % 2 == 1) : 1'b0;
    r.fe   = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) r.fe = 1'b1;
    r.cyc  = 0;
    return r;
  endfunction

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  task automatic send_frame(input int sel, input int bit_clks, input logic [8:0] data,
                            input int nbits, input int par_mode, input logic pbit,
                            input logic [1:0] stops, input int nstop);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (par_mode != 0) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
    for (int i = 0; i < bits.size(); i++) begin
      set_line(sel, bits[i]);
      repeat (bit_clks) @(negedge clk);
    end
  endtask

  task automatic wait_rec(input int sel, input int budget, output bit got, output rec_t r);
    got = 1'b0;
    r = '{data: '0, fe: 1'b0, pe: 1'b0, cyc: 0};
    for (int i = 0; i <= budget; i++) begin
      if (sel == 0 && q_a.size() > 0) begin r = q_a.pop_front(); got = 1'b1; end
      else if (sel == 1 && q_b.size() > 0) begin r = q_b.pop_front(); got = 1'b1; end
      else if (sel == 2 && q_c.size() > 0) begin r = q_c.pop_front(); got = 1'b1; end
      if (got) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({data_a, valid_a, busy_a, ferr_a, perr_a} !== 12'h000) begin
      miscompares++; $display("FAIL reset_a: got %h want 000", {data_a, valid_a, busy_a, ferr_a, perr_a});
    end
    vectors++;
    if ({data_b, valid_b, busy_b, ferr_b, perr_b} !== 12'h000) begin
      miscompares++; $display("FAIL reset_b: got %h want 000", {data_b, valid_b, busy_b, ferr_b, perr_b});
    end
    vectors++;
    if ({data_c, valid_c, busy_c, ferr_c, perr_c} !== 11'h000) begin
      miscompares++; $display("FAIL reset_c: got %h want 000", {data_c, valid_c, busy_c, ferr_c, perr_c});
    end
`ifdef UART_RX_BREAK_DET_EN
    vectors++;
    if ({brk_a, brk_b, brk_c} !== 3'b000) begin
      miscompares++; $display("FAIL reset_brk: got %b want 000", {brk_a, brk_b, brk_c});
    end
`endif
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    vectors++;
    if ({busy_a, busy_b, busy_c} !== 3'b000 || q_a.size() + q_b.size() + q_c.size() != 0) begin
      miscompares++;
      $display("FAIL release_idle: busy %b pulses %0d want busy 000 pulses 0",
               {busy_a, busy_b, busy_c}, q_a.size() + q_b.size() + q_c.size());
    end
  endtask

  task automatic test_basic_8n1();
    rec_t exp, r;
    bit   got;
    int   t0, lat;
    exp = model(9'h0A5, 8, 0, 1'b0, 2'b11, 1);
    t0  = cyc;
    send_frame(0, BIT_A, 9'h0A5, 8, 0, 1'b0, 2'b11, 1);
    set_line(0, 1'b1);
    wait_rec(0, 2 * BIT_A, got, r);
    vectors++;
    if ({got, r.data, r.fe, r.pe} !== {1'b1, exp.data, exp.fe, exp.pe}) begin
      miscompares++;
      $display("FAIL a5_frame: got valid/data/fe/pe %b/%h/%b/%b want 1/%h/%b/%b",
               got, r.data, r.fe, r.pe, exp.data, exp.fe, exp.pe);
    end
    lat = r.cyc - t0;
    vectors++;
    if (lat < BIT_A * 37 / 4 || lat > BIT_A * 10) begin
      miscompares++; $display("FAIL a5_latency: got %0d clks want %0d..%0d", lat, BIT_A * 37 / 4, BIT_A * 10);
    end
    vectors++;
    if (busy_a !== 1'b0 || q_a.size() != 0) begin
      miscompares++; $display("FAIL a5_after: busy %b extra pulses %0d want 0 0", busy_a, q_a.size());
    end
  endtask

  task automatic test_frame_error();
    logic [8:0] words [2] = '{9'h055, 9'h00F};
    logic [1:0] stops [2] = '{2'b10, 2'b11};
    rec_t exp, r;
    bit   got;
    for (int i = 0; i < 2; i++) begin
      exp = model(words[i], 8, 0, 1'b0, stops[i], 1);
      send_frame(0, BIT_A, words[i], 8, 0, 1'b0, stops[i], 1);
      set_line(0, 1'b1);
      wait_rec(0, 2 * BIT_A, got, r);
      vectors++;
      if ({got, r.data, r.fe, r.pe} !== {1'b1, exp.data, exp.fe, exp.pe}) begin
        miscompares++;
        $display("FAIL frame_err_%0d: got valid/data/fe/pe %b/%h/%b/%b want 1/%h/%b/%b",
                 i, got, r.data, r.fe, r.pe, exp.data, exp.fe, exp.pe);
      end
      repeat (BIT_A) @(negedge clk);
    end
  endtask

  task automatic test_false_start();
    bit seen_busy = 1'b0;
    set_line(0, 1'b0);
    repeat (150) begin @(negedge clk); if (busy_a === 1'b1) seen_busy = 1'b1; end
    set_line(0, 1'b1);
    repeat (BIT_A - 150) begin @(negedge clk); if (busy_a === 1'b1) seen_busy = 1'b1; end
    vectors++;
    if (seen_busy !== 1'b1 || busy_a !== 1'b0) begin
      miscompares++; $display("FAIL glitch_busy: seen %b now %b want 1 0", seen_busy, busy_a);
    end
    repeat (BIT_A) @(negedge clk);
    vectors++;
    if (q_a.size() != 0) begin
      miscompares++; $display("FAIL glitch_valid: got %0d pulses want 0", q_a.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] words [3] = '{9'h000, 9'h0FF, 9'h081};
    rec_t exp, r;
    bit   got;
    int   prev;
    for (int i = 0; i < 3; i++) send_frame(0, BIT_A, words[i], 8, 0, 1'b0, 2'b11, 1);
    set_line(0, 1'b1);
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      exp = model(words[i], 8, 0, 1'b0, 2'b11, 1);
      wait_rec(0, 2 * BIT_A, got, r);
      vectors++;
      if ({got, r.data, r.fe, r.pe} !== {1'b1, exp.data, exp.fe, exp.pe}) begin
        miscompares++;
        $display("FAIL b2b_%0d: got valid/data/fe/pe %b/%h/%b/%b want 1/%h/%b/%b",
                 i, got, r.data, r.fe, r.pe, exp.data, exp.fe, exp.pe);
      end
      if (i > 0) begin
        vectors++;
        if (r.cyc - prev != 10 * BIT_A) begin
          miscompares++; $display("FAIL b2b_spacing_%0d: got %0d clks want %0d", i, r.cyc - prev, 10 * BIT_A);
        end
      end
      prev = r.cyc;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] partial = 5'b01101;
    rec_t exp, r;
    bit   got;
    for (int i = 0; i < 5; i++) begin
      set_line(0, partial[i]);
      repeat (BIT_A) @(negedge clk);
    end
    vectors++;
    if (busy_a !== 1'b1) begin
      miscompares++; $display("FAIL mid_busy: got %b want 1", busy_a);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({data_a, valid_a, busy_a, ferr_a, perr_a} !== 12'h000) begin
      miscompares++; $display("FAIL mid_reset: got %h want 000", {data_a, valid_a, busy_a, ferr_a, perr_a});
    end
    set_line(0, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT_A) @(negedge clk);
    vectors++;
    if (q_a.size() != 0 || busy_a !== 1'b0) begin
      miscompares++; $display("FAIL mid_discard: pulses %0d busy %b want 0 0", q_a.size(), busy_a);
    end
    exp = model(9'h05A, 8, 0, 1'b0, 2'b11, 1);
    send_frame(0, BIT_A, 9'h05A, 8, 0, 1'b0, 2'b11, 1);
    set_line(0, 1'b1);
    wait_rec(0, 2 * BIT_A, got, r);
    vectors++;
    if ({got, r.data, r.fe, r.pe} !== {1'b1, exp.data, exp.fe, exp.pe}) begin
      miscompares++;
      $display("FAIL after_reset_5a: got valid/data/fe/pe %b/%h/%b/%b want 1/%h/%b/%b",
               got, r.data, r.fe, r.pe, exp.data, exp.fe, exp.pe);
    end
  endtask

`ifdef UART_RX_BREAK_DET_EN
  task automatic test_break();
    rec_t r;
    bit   got;
    vectors++;
    if (brk_a !== 1'b0) begin
      miscompares++; $display("FAIL brk_before: got %b want 0", brk_a);
    end
    set_line(0, 1'b0);
    repeat (20 * BIT_A) @(negedge clk);
    wait_rec(0, 0, got, r);
    vectors++;
    if ({got, r.data, r.fe, brk_a, busy_a, q_a.size() == 0} !== {1'b1, 9'h000, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL brk_hold: got valid/data/fe/brk/busy/single %b/%h/%b/%b/%b/%b want 1/000/1/1/0/1",
               got, r.data, r.fe, brk_a, busy_a, q_a.size() == 0);
    end
    set_line(0, 1'b1);
    repeat (5) @(negedge clk);
    vectors++;
    if ({brk_a, brk_b, brk_c} !== 3'b000) begin
      miscompares++; $display("FAIL brk_release: got %b want 000", {brk_a, brk_b, brk_c});
    end
    repeat (BIT_A) @(negedge clk);
  endtask
`endif

  task automatic test_parity_even();
    logic [8:0] data;
    logic       pbit;
    rec_t       exp, r;
    bit         got;
    for (int i = 0; i < 12; i++) begin
      data = (i < 2) ? 9'h03C : 9'($urandom);
      pbit = (i < 2) ? i[0] : 1'($urandom_range(0, 1));
      exp  = model(data, 8, 2, pbit, 2'b11, 1);
      send_frame(1, BIT_B, data, 8, 2, pbit, 2'b11, 1);
      set_line(1, 1'b1);
      wait_rec(1, 2 * BIT_B, got, r);
      vectors++;
      if ({got, r.data, r.fe, r.pe} !== {1'b1, exp.data, exp.fe, exp.pe}) begin
        miscompares++;
        $display("FAIL parity_%0d: got valid/data/fe/pe %b/%h/%b/%b want 1/%h/%b/%b",
                 i, got, r.data, r.fe, r.pe, exp.data, exp.fe, exp.pe);
      end
      repeat (BIT_B) @(negedge clk);
    end
  endtask

  task automatic test_b2b_7o2();
    rec_t       exp_q[$];
    rec_t       exp, r;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;
    bit         got;
    for (int i = 0; i < 8; i++) begin
      data  = 9'($urandom);
      pbit  = 1'($urandom_range(0, 1));
      stops = {1'b1, ($urandom_range(0, 3) != 0)};
      exp_q.push_back(model(data, 7, 1, pbit, stops, 2));
      send_frame(2, BIT_C, data, 7, 1, pbit, stops, 2);
    end
    set_line(2, 1'b1);
    repeat (BIT_C) @(negedge clk);
    vectors++;
    if (q_c.size() != 8) begin
      miscompares++; $display("FAIL b2b_7o2_count: got %0d pulses want 8", q_c.size());
    end
    for (int i = 0; i < 8; i++) begin
      exp = exp_q[i];
      wait_rec(2, 0, got, r);
      vectors++;
      if ({got, r.data, r.fe, r.pe} !== {1'b1, exp.data, exp.fe, exp.pe}) begin
        miscompares++;
        $display("FAIL b2b_7o2_%0d: got valid/data/fe/pe %b/%h/%b/%b want 1/%h/%b/%b",
                 i, got, r.data, r.fe, r.pe, exp.data, exp.fe, exp.pe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_frame_error();
    test_false_start();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_BREAK_DET_EN
    test_break();
`endif
    test_parity_even();
    test_b2b_7o2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_500_000;
    $display("FAIL watchdog: run exceeded 2.5 ms of simulated time");
    $fatal(1, "watchdog expired");
  end

endmodule
